// File: rtl/slc3_input_conditioner_pkg.sv
// Shared types for the slc3 board front end: per-button debounce state and
// the held/released decode used by the debounce channels.
package lc3b_types;

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      PRESS_CHK   = 2'd1,
      PRESSED     = 2'd2,
      RELEASE_CHK = 2'd3
   } btn_state_t;

   localparam int SW_WIDTH = 16;

   // A button counts as held until its release has been fully qualified.
   function automatic logic btn_is_held(input btn_state_t s);
      return (s == PRESSED) || (s == RELEASE_CHK);
   endfunction

endpackage

// File: rtl/slc3_input_conditioner_debounce.sv
// One pushbutton channel: synchronizer, debounce FSM with qualification counter,
// and registered level / single-cycle press-pulse outputs.
//
// state       | meaning
// RELEASED    | button accepted as released, level 0
// PRESS_CHK   | sync low seen, counting stable-low cycles before accepting press
// PRESSED     | button accepted as held, level 1
// RELEASE_CHK | sync high seen, counting stable-high cycles before accepting release
module button_debounce_channel
   import lc3b_types::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int SYNC_STAGES     = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn_n,
   output logic o_level,
   output logic o_pulse
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_sync_n;
   btn_state_t             r_state;
   btn_state_t             w_state_nxt;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic                   w_cnt_tc;
   logic                   r_level;
   logic                   r_pulse;
   logic                   w_level_nxt;
   logic                   w_pulse_nxt;

   // Synchronizer idles at 1 so reset looks like a released button.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn_n};
      end
   end

   assign w_sync_n = r_sync[SYNC_STAGES-1];
   assign w_cnt_tc = (r_cnt == CNT_TC);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= RELEASED;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_level <= w_level_nxt;
         r_pulse <= w_pulse_nxt;
      end
   end

   // The counter only advances inside a CHK state and leaves before reaching
   // DEBOUNCE_CYCLES, so it can never wrap.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         RELEASED: begin
            if (!w_sync_n) begin
               w_state_nxt = PRESS_CHK;
               w_cnt_nxt   = '0;
            end
         end
         PRESS_CHK: begin
            if (w_sync_n) begin
               w_state_nxt = RELEASED;
            end else if (w_cnt_tc) begin
               w_state_nxt = PRESSED;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (w_sync_n) begin
               w_state_nxt = RELEASE_CHK;
               w_cnt_nxt   = '0;
            end
         end
         RELEASE_CHK: begin
            if (!w_sync_n) begin
               w_state_nxt = PRESSED;
            end else if (w_cnt_tc) begin
               w_state_nxt = RELEASED;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = RELEASED;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      w_level_nxt = btn_is_held(w_state_nxt);
      w_pulse_nxt = (r_state == PRESS_CHK) && (w_state_nxt == PRESSED);
   end

   assign o_level = r_level;
   assign o_pulse = r_pulse;

endmodule

// File: rtl/slc3_input_conditioner.sv
// Board front end for slc3: debounced Run/Continue channels plus a plain
// multi-flop synchronizer for the slide switches.
module slc3_input_conditioner
   import lc3b_types::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int SYNC_STAGES     = 2
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                Run_n,
   input  logic                Continue_n,
   input  logic [SW_WIDTH-1:0] Switches_raw,
   output logic                Run_level,
   output logic                Run_pulse,
   output logic                Continue_level,
   output logic                Continue_pulse,
   output logic [SW_WIDTH-1:0] Switches_sync
);

   logic [SW_WIDTH-1:0] r_sw_sync [SYNC_STAGES];

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_sw_sync[i] <= '0;
         end
      end else begin
         r_sw_sync[0] <= Switches_raw;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sw_sync[i] <= r_sw_sync[i-1];
         end
      end
   end

   assign Switches_sync = r_sw_sync[SYNC_STAGES-1];

   // Channels take the raw active-low button and hand back active-high outputs.
   button_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
   ) u_run (
      .i_clk   (Clk),
      .i_rst   (Reset),
      .i_btn_n (Run_n),
      .o_level (Run_level),
      .o_pulse (Run_pulse)
   );

   button_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
   ) u_continue (
      .i_clk   (Clk),
      .i_rst   (Reset),
      .i_btn_n (Continue_n),
      .o_level (Continue_level),
      .o_pulse (Continue_pulse)
   );

endmodule

// File: tb/tb_slc3_input_conditioner.sv
// Scoreboard bench for slc3_input_conditioner: a delay-line plus run-length
// reference model queues expected outputs; a monitor compares every cycle.
module tb_slc3_input_conditioner;

   localparam int D = 4;
   localparam int S = 2;

   typedef struct packed {
      logic        rl;
      logic        rp;
      logic        cl;
      logic        cp;
      logic [15:0] sw;
   } obs_t;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Run_n;
   logic        Continue_n;
   logic [15:0] Switches_raw;
   logic        Run_level;
   logic        Run_pulse;
   logic        Continue_level;
   logic        Continue_pulse;
   logic [15:0] Switches_sync;

   always #5 Clk = ~Clk;

   slc3_input_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .SYNC_STAGES     (S)
   ) dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .Run_n          (Run_n),
      .Continue_n     (Continue_n),
      .Switches_raw   (Switches_raw),
      .Run_level      (Run_level),
      .Run_pulse      (Run_pulse),
      .Continue_level (Continue_level),
      .Continue_pulse (Continue_pulse),
      .Switches_sync  (Switches_sync)
   );

   obs_t exp_q[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   run_pulses = 0;
   int   cont_pulses = 0;
   int   last_run_pulse = -1;
   int   last_cont_pulse = -1;
   int   last_run_fall = -1;

   // Reference model: raw value delayed S edges, then a press/release is
   // accepted once D+1 consecutive samples disagree with the accepted level.
   logic        m_pipe [2][S];
   logic        m_lvl  [2];
   int          m_run  [2];
   logic [15:0] m_sw   [S];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
   endtask

   task automatic model_step(input logic rst, input logic rn, input logic cn, input logic [15:0] sw);
      obs_t e;
      logic raw [2];
      logic pul [2];
      logic pressed;
      raw[0] = rn;
      raw[1] = cn;
      for (int ch = 0; ch < 2; ch++) begin
         pul[ch] = 1'b0;
         if (rst) begin
            for (int k = 0; k < S; k++) m_pipe[ch][k] = 1'b1;
            m_lvl[ch] = 1'b0;
            m_run[ch] = 0;
         end else begin
            pressed = !m_pipe[ch][S-1];
            for (int k = S-1; k > 0; k--) m_pipe[ch][k] = m_pipe[ch][k-1];
            m_pipe[ch][0] = raw[ch];
            if (pressed != m_lvl[ch]) begin
               m_run[ch]++;
               if (m_run[ch] == D + 1) begin
                  m_lvl[ch] = pressed;
                  m_run[ch] = 0;
                  pul[ch]   = pressed;
               end
            end else begin
               m_run[ch] = 0;
            end
         end
      end
      if (rst) begin
         for (int k = 0; k < S; k++) m_sw[k] = 16'h0000;
      end else begin
         for (int k = S-1; k > 0; k--) m_sw[k] = m_sw[k-1];
         m_sw[0] = sw;
      end
      e.rl = m_lvl[0];
      e.rp = pul[0];
      e.cl = m_lvl[1];
      e.cp = pul[1];
      e.sw = m_sw[S-1];
      exp_q.push_back(e);
   endtask

   // Drive one cycle of inputs at the falling edge; the following rising edge samples them.
   task automatic step(input logic rst, input logic rn, input logic cn, input logic [15:0] sw);
      @(negedge Clk);
      Reset        = rst;
      Run_n        = rn;
      Continue_n   = cn;
      Switches_raw = sw;
      if (rst) begin
         #1;
         check("reset_async_outputs",
               {Run_level, Run_pulse, Continue_level, Continue_pulse, Switches_sync}, 32'h0);
      end
      model_step(rst, rn, cn, sw);
   endtask

   // Monitor: pops one expectation per rising edge once stimulus has started.
   initial begin
      obs_t e;
      obs_t a;
      logic prp = 1'b0;
      logic pcp = 1'b0;
      logic prl = 1'b0;
      forever begin
         @(posedge Clk);
         cyc++;
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {Run_level, Run_pulse, Continue_level, Continue_pulse, Switches_sync};
            check("outputs_vs_model", 32'(a), 32'(e));
            check("run_pulse_one_cycle", {31'b0, prp & Run_pulse}, 32'h0);
            check("cont_pulse_one_cycle", {31'b0, pcp & Continue_pulse}, 32'h0);
            if (Run_pulse) begin
               run_pulses++;
               last_run_pulse = cyc;
            end
            if (Continue_pulse) begin
               cont_pulses++;
               last_cont_pulse = cyc;
            end
            if (prl && !Run_level) last_run_fall = cyc;
            prp = Run_pulse;
            pcp = Continue_pulse;
            prl = Run_level;
         end
      end
   end

   initial begin
      int          base;
      int          rp0;
      int          cp0;
      int          hold_r;
      int          hold_c;
      logic        rn;
      logic        cn;
      logic        rst;
      logic [4:0]  bounce;

      Reset        = 1'b1;
      Run_n        = 1'b1;
      Continue_n   = 1'b1;
      Switches_raw = 16'h1234;
      repeat (3) step(1'b1, 1'b1, 1'b1, 16'h1234);

      // Switches: synchronized, no debounce.
      step(1'b0, 1'b1, 1'b1, 16'hA5C3);
      repeat (3) step(1'b0, 1'b1, 1'b1, 16'hA5C3);
      check("switches_direct", {16'h0, Switches_sync}, 32'h0000_A5C3);

      // Clean Run press: pulse after edge 7 only.
      rp0 = run_pulses;
      step(1'b0, 1'b0, 1'b1, 16'hA5C3);
      base = cyc + 1;
      repeat (11) step(1'b0, 1'b0, 1'b1, 16'hA5C3);
      check("run_press_latency", 32'(last_run_pulse - base + 1), 32'd7);
      check("run_press_count", 32'(run_pulses - rp0), 32'd1);
      check("run_level_held", {31'b0, Run_level}, 32'd1);

      // Clean Run release: level drops after edge 7, no pulse.
      rp0 = run_pulses;
      step(1'b0, 1'b1, 1'b1, 16'h0F0F);
      base = cyc + 1;
      repeat (11) step(1'b0, 1'b1, 1'b1, 16'h0F0F);
      check("run_release_latency", 32'(last_run_fall - base + 1), 32'd7);
      check("run_release_no_pulse", 32'(run_pulses - rp0), 32'd0);

      // Press bounce: 0,0,1,0,1 then released.
      rp0 = run_pulses;
      bounce = 5'b10100;
      for (int i = 0; i < 5; i++) step(1'b0, bounce[i], 1'b1, 16'h0F0F);
      repeat (10) step(1'b0, 1'b1, 1'b1, 16'h0F0F);
      check("run_bounce_no_pulse", 32'(run_pulses - rp0), 32'd0);
      check("run_bounce_level", {31'b0, Run_level}, 32'd0);

      // Continue press then a 3-cycle release bounce.
      cp0 = cont_pulses;
      repeat (12) step(1'b0, 1'b1, 1'b0, 16'h5555);
      repeat (3)  step(1'b0, 1'b1, 1'b1, 16'h5555);
      repeat (10) step(1'b0, 1'b1, 1'b0, 16'h5555);
      check("cont_release_bounce_pulses", 32'(cont_pulses - cp0), 32'd1);
      check("cont_release_bounce_level", {31'b0, Continue_level}, 32'd1);
      repeat (12) step(1'b0, 1'b1, 1'b1, 16'h5555);

      // Simultaneous presses.
      step(1'b0, 1'b0, 1'b0, 16'hFFFF);
      base = cyc + 1;
      repeat (11) step(1'b0, 1'b0, 1'b0, 16'hFFFF);
      check("simul_run_latency", 32'(last_run_pulse - base + 1), 32'd7);
      check("simul_cont_latency", 32'(last_cont_pulse - base + 1), 32'd7);
      repeat (12) step(1'b0, 1'b1, 1'b1, 16'hFFFF);

      // Reset while Run is in its press check, button still held.
      rp0 = run_pulses;
      repeat (4) step(1'b0, 1'b0, 1'b1, 16'h00FF);
      repeat (2) step(1'b1, 1'b0, 1'b1, 16'h00FF);
      check("reset_midcheck_no_pulse", 32'(run_pulses - rp0), 32'd0);
      step(1'b0, 1'b0, 1'b1, 16'h00FF);
      base = cyc + 1;
      repeat (11) step(1'b0, 1'b0, 1'b1, 16'h00FF);
      check("reset_requalify_latency", 32'(last_run_pulse - base + 1), 32'd7);
      check("reset_requalify_count", 32'(run_pulses - rp0), 32'd1);
      repeat (12) step(1'b0, 1'b1, 1'b1, 16'h00FF);

      // Random phase: independent random hold lengths, random switches, rare resets.
      hold_r = 0;
      hold_c = 0;
      rn = 1'b1;
      cn = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (hold_r == 0) begin
            rn = ~rn;
            hold_r = $urandom_range(1, 12);
         end
         hold_r--;
         if (hold_c == 0) begin
            cn = ~cn;
            hold_c = $urandom_range(1, 12);
         end
         hold_c--;
         rst = ($urandom_range(0, 399) == 0);
         step(rst, rn, cn, 16'($urandom));
      end
      repeat (15) step(1'b0, 1'b1, 1'b1, 16'h0000);

      repeat (3) @(negedge Clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
